// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the instruction prefetch unit.
package fetch_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 12;
    localparam int unsigned DEF_RESET_PC   = 0;

    // One prefetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] pc;
        logic [DEF_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through FIFO holding prefetched instructions; supports flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  entry_t                 push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output entry_t                 head_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            do_push;
    logic            do_pop;

    // Pointer and occupancy update; flush wins over any push or pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && !flush_i && ((count_q < CW'(DEPTH)) || do_pop);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; written only on an accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch unit: PC, in-flight tracking and issue logic in front of a prefetch FIFO.
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned RESET_PC    = DEF_RESET_PC
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         mem_rd_en,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [DATA_WIDTH-1:0]        mem_rdata,
    input  logic                         redirect_valid,
    input  logic [ADDR_WIDTH-1:0]        redirect_pc,
    output logic                         instr_valid,
    output logic [DATA_WIDTH-1:0]        instr,
    output logic [ADDR_WIDTH-1:0]        instr_pc,
    input  logic                         instr_ready,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count
);

    localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q,   req_pc_d;
    logic                  req_valid_q, req_valid_d;
    entry_t                last_q,     last_d;

    entry_t                head;
    entry_t                push_data;
    logic                  fifo_valid;
    logic [CW-1:0]         count;
    logic [OW-1:0]         occupancy;
    logic                  issue;
    logic                  push;
    logic                  pop;

    // Issue a read only when the queue has room for everything already in flight.
    always_comb begin
        occupancy = OW'(count) + OW'(req_valid_q);
        issue     = !reset && !redirect_valid && (occupancy < OW'(QUEUE_DEPTH));
    end

    // Next PC, in-flight request tracking and FIFO push/pop control.
    always_comb begin
        fetch_pc_d      = fetch_pc_q;
        req_valid_d     = issue;
        req_pc_d        = fetch_pc_q;
        push            = req_valid_q && !redirect_valid;
        push_data.pc    = req_pc_q;
        push_data.instr = mem_rdata;
        instr_valid     = fifo_valid && !redirect_valid;
        pop             = instr_valid && instr_ready;
        last_d          = fifo_valid ? head : last_q;
        if (redirect_valid) begin
            fetch_pc_d  = redirect_pc;
            req_valid_d = 1'b0;
        end else if (issue) begin
            fetch_pc_d  = fetch_pc_q + ADDR_WIDTH'(1);
        end
    end

    // PC, in-flight request and last-delivered head registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q  <= ADDR_WIDTH'(RESET_PC);
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
            last_q      <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
            last_q      <= last_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (QUEUE_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (head),
        .valid_o     (fifo_valid),
        .count_o     (count)
    );

    // When the queue drains, the outputs keep showing the last head seen.
    assign instr       = fifo_valid ? head.instr : last_q.instr;
    assign instr_pc    = fifo_valid ? head.pc    : last_q.pc;
    assign mem_rd_en   = issue;
    assign mem_addr    = fetch_pc_q;
    assign queue_count = count;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue: directed phases push expected
// {pc, instr} pairs; a monitor pops and compares each delivered instruction.
module tb_fetch_prefetch_queue;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 12;
    localparam int unsigned QD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
    logic [2:0]    queue_count;

    logic [DW-1:0] mem [4096];
    logic [AW+DW-1:0] exp_q [$];

    int vectors     = 0;
    int miscompares = 0;
    int consumed    = 0;

    fetch_prefetch_queue #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .QUEUE_DEPTH (QD),
        .RESET_PC    (0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .queue_count    (queue_count)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected stream from start: pc wraps at 12 bits, instr = 0x1000 + pc.
    task automatic push_exp(input logic [AW-1:0] start, input int n);
        logic [AW-1:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = start + AW'(i);
            exp_q.push_back({pc, 16'h1000 + 16'(pc)});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_consumed(input int target);
        int n;
        n = 0;
        while (consumed < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (consumed < target) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: consumed %0d, expected %0d", consumed, target);
        end
        #1;
    endtask

    task automatic monitor();
        logic [AW+DW-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset && instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_instr: got pc 0x%0h instr 0x%0h, expected nothing", instr_pc, instr);
                end else begin
                    e = exp_q.pop_front();
                    check("head_pc", 32'(instr_pc), 32'(e[AW+DW-1:DW]));
                    check("head_instr", 32'(instr), 32'(e[DW-1:0]));
                end
                consumed++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h1000 + 16'(i);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        fork
            monitor();
            begin : stimulus
                int  cycles;
                logic found;
                logic prev_rd;

                // Reset state
                step(); step();
                check("rst_instr_valid", 32'(instr_valid), 32'd0);
                check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
                check("rst_mem_addr", 32'(mem_addr), 32'd0);
                check("rst_queue_count", 32'(queue_count), 32'd0);
                check("rst_instr", 32'(instr), 32'd0);
                check("rst_instr_pc", 32'(instr_pc), 32'd0);

                // Streaming from RESET_PC with decode always ready
                push_exp(12'h000, 20);
                instr_ready = 1'b1;
                reset = 1'b0;
                #1;
                check("c0_mem_rd_en", 32'(mem_rd_en), 32'd1);
                check("c0_mem_addr", 32'(mem_addr), 32'h000);
                check("c0_instr_valid", 32'(instr_valid), 32'd0);
                step();
                check("c1_instr_valid", 32'(instr_valid), 32'd0);
                check("c1_mem_addr", 32'(mem_addr), 32'h001);
                step();
                check("c2_instr_valid", 32'(instr_valid), 32'd1);
                check("c2_instr", 32'(instr), 32'h1000);
                check("c2_instr_pc", 32'(instr_pc), 32'h000);
                cycles = 0;
                while (consumed < 20 && cycles < 100) begin
                    step();
                    cycles++;
                end
                check("stream_cycles_20", 32'(cycles), 32'd20);

                // Back-pressure fills the queue and stops issue
                instr_ready = 1'b0;
                repeat (10) step();
                check("bp_queue_count", 32'(queue_count), 32'd4);
                check("bp_mem_rd_en", 32'(mem_rd_en), 32'd0);
                check("bp_head_pc", 32'(instr_pc), 32'h014);
                push_exp(12'h014, 20);
                instr_ready = 1'b1;
                #1;
                check("bp_release_no_issue", 32'(mem_rd_en), 32'd0);
                wait_consumed(40);

                // Redirect with three queued entries and one in flight
                instr_ready = 1'b0;
                found = 1'b0;
                for (int i = 0; i < 20 && !found; i++) begin
                    @(negedge clk);
                    prev_rd = mem_rd_en;
                    step();
                    if (queue_count == 3'd3 && prev_rd) found = 1'b1;
                end
                check("redir_setup_found", 32'(found), 32'd1);
                push_exp(12'h080, 10);
                redirect_valid = 1'b1;
                redirect_pc    = 12'h080;
                instr_ready    = 1'b1;
                #1;
                check("redir_t_instr_valid", 32'(instr_valid), 32'd0);
                check("redir_t_mem_rd_en", 32'(mem_rd_en), 32'd0);
                step();
                redirect_valid = 1'b0;
                #1;
                check("redir_t1_instr_valid", 32'(instr_valid), 32'd0);
                check("redir_t1_queue_count", 32'(queue_count), 32'd0);
                check("redir_t1_mem_rd_en", 32'(mem_rd_en), 32'd1);
                check("redir_t1_mem_addr", 32'(mem_addr), 32'h080);
                step();
                check("redir_t2_instr_valid", 32'(instr_valid), 32'd0);
                step();
                check("redir_t3_instr_valid", 32'(instr_valid), 32'd1);
                check("redir_t3_instr_pc", 32'(instr_pc), 32'h080);
                wait_consumed(50);

                // Back-to-back redirects: the second target wins
                instr_ready = 1'b0;
                repeat (3) step();
                push_exp(12'h020, 6);
                redirect_valid = 1'b1;
                redirect_pc    = 12'h010;
                instr_ready    = 1'b1;
                step();
                redirect_pc    = 12'h020;
                step();
                redirect_valid = 1'b0;
                wait_consumed(56);

                // PC wraps from 0xFFF to 0x000
                instr_ready = 1'b0;
                step();
                push_exp(12'hFFE, 6);
                redirect_valid = 1'b1;
                redirect_pc    = 12'hFFE;
                instr_ready    = 1'b1;
                step();
                redirect_valid = 1'b0;
                wait_consumed(62);

                // Asynchronous reset with the queue full
                instr_ready = 1'b0;
                repeat (10) step();
                check("prereset_queue_count", 32'(queue_count), 32'd4);
                reset = 1'b1;
                #1;
                check("midrst_instr_valid", 32'(instr_valid), 32'd0);
                check("midrst_mem_rd_en", 32'(mem_rd_en), 32'd0);
                check("midrst_queue_count", 32'(queue_count), 32'd0);
                check("midrst_instr", 32'(instr), 32'd0);
                step(); step();
                push_exp(12'h000, 4);
                instr_ready = 1'b1;
                reset = 1'b0;
                #1;
                check("restart_mem_addr", 32'(mem_addr), 32'h000);
                wait_consumed(66);
                check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $finish;
            end
        join
    end

endmodule
